// File: rtl/bsg_fifo_arb_pkg.sv
// Shared types and sizing helpers for the round-robin FIFO enqueue arbiter.
package bsg_fifo_arb_pkg;

  typedef enum logic {
    e_idle   = 1'b0,
    e_locked = 1'b1
  } arb_state_e;

  // Occupancy counter must represent 0..els inclusive.
  function automatic int unsigned occ_width(input int unsigned els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bsg_rr_pick.sv
// Rotate-priority encoder: first set request searching cyclically from ptr+1.
module bsg_rr_pick
  import bsg_fifo_arb_pkg::*;
#(
  parameter int unsigned num_req_p = 4
) (
  input  logic [num_req_p-1:0]         req,
  input  logic [$clog2(num_req_p)-1:0] ptr,
  output logic [num_req_p-1:0]         grant,
  output logic [$clog2(num_req_p)-1:0] id
);

  localparam int unsigned id_width_lp = $clog2(num_req_p);

  logic [id_width_lp-1:0] idx;
  logic                   found;

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= num_req_p; k++) begin
      idx = id_width_lp'((32'(ptr) + k) % num_req_p);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end

endmodule

// File: rtl/bsg_fifo_rr_enq_arb.sv
// Round-robin, packet-locking enqueue arbiter in front of a small FIFO,
// with mirrored occupancy and a sticky overflow/underflow flag.
module bsg_fifo_rr_enq_arb
  import bsg_fifo_arb_pkg::*;
#(
  parameter int unsigned num_req_p      = 4,
  parameter int unsigned width_p        = 32,
  parameter int unsigned els_p          = 4,
  parameter int unsigned lock_packets_p = 1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p-1:0]             v_i,
  input  logic [num_req_p*width_p-1:0]     data_i,
  input  logic [num_req_p-1:0]             last_i,
  output logic [num_req_p-1:0]             ready_o,
  output logic                             fifo_v_o,
  output logic [width_p-1:0]               fifo_data_o,
  input  logic                             fifo_ready_i,
  input  logic                             fifo_yumi_i,
  output logic [$clog2(num_req_p)-1:0]     grant_id_o,
  output logic                             locked_o,
  output logic [occ_width(els_p)-1:0]      occupancy_o,
  output logic                             err_o
);

  localparam int unsigned id_width_lp  = $clog2(num_req_p);
  localparam int unsigned occ_width_lp = occ_width(els_p);

  arb_state_e              state_q, state_n;
  logic [id_width_lp-1:0]  owner_q, owner_n;
  logic [id_width_lp-1:0]  ptr_q, ptr_n;
  logic [occ_width_lp-1:0] occ_q, occ_n;
  logic                    err_q, err_n;

  logic [num_req_p-1:0]    pick_grant;
  logic [id_width_lp-1:0]  pick_id;
  logic [num_req_p-1:0]    grant;
  logic                    last_sel;
  logic                    enq;

  bsg_rr_pick #(.num_req_p(num_req_p)) u_pick (
    .req   (v_i),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .id    (pick_id)
  );

  // Grant steering: the owner holds the port while a packet is in flight.
  always_comb begin
    grant      = pick_grant;
    grant_id_o = pick_id;
    fifo_v_o   = |v_i;
    if (state_q == e_locked) begin
      grant_id_o = owner_q;
      fifo_v_o   = v_i[owner_q];
      for (int i = 0; i < int'(num_req_p); i++) begin
        grant[i] = (owner_q == id_width_lp'(i));
      end
    end
  end

  always_comb begin
    fifo_data_o = '0;
    for (int i = 0; i < int'(num_req_p); i++) begin
      if (grant_id_o == id_width_lp'(i)) begin
        fifo_data_o = data_i[i*width_p +: width_p];
      end
    end
  end

  assign ready_o     = grant & {num_req_p{fifo_ready_i}};
  assign last_sel    = last_i[grant_id_o];
  assign enq         = fifo_v_o & fifo_ready_i;
  assign locked_o    = (state_q == e_locked);
  assign occupancy_o = occ_q;
  assign err_o       = err_q;

  // Next-state, owner and last-served pointer.
  always_comb begin
    state_n = state_q;
    owner_n = owner_q;
    ptr_n   = ptr_q;
    unique case (state_q)
      e_idle: begin
        if (enq) begin
          if ((lock_packets_p != 0) && !last_sel) begin
            state_n = e_locked;
            owner_n = grant_id_o;
          end else begin
            ptr_n = grant_id_o;
          end
        end
      end
      e_locked: begin
        if (enq && last_sel) begin
          state_n = e_idle;
          ptr_n   = owner_q;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  // Mirrored occupancy; saturates instead of wrapping on error.
  always_comb begin
    occ_n = occ_q;
    err_n = err_q;
    if (enq && !fifo_yumi_i) begin
      if (occ_q == occ_width_lp'(els_p)) err_n = 1'b1;
      else                               occ_n = occ_q + occ_width_lp'(1);
    end else if (!enq && fifo_yumi_i) begin
      if (occ_q == '0) err_n = 1'b1;
      else             occ_n = occ_q - occ_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      owner_q <= '0;
      ptr_q   <= id_width_lp'(num_req_p - 1);
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      owner_q <= owner_n;
      ptr_q   <= ptr_n;
      occ_q   <= occ_n;
      err_q   <= err_n;
    end
  end

endmodule

// File: tb/tb_bsg_fifo_rr_enq_arb.sv
// Directed bench for bsg_fifo_rr_enq_arb: fairness, locking, backpressure,
// bubbles, underflow/overflow and reset mid-packet.
module tb_bsg_fifo_rr_enq_arb;

  logic         clk_i;
  logic         reset_n_i;
  logic [3:0]   v_i;
  logic [127:0] data_i;
  logic [3:0]   last_i;
  logic [3:0]   ready_o;
  logic         fifo_v_o;
  logic [31:0]  fifo_data_o;
  logic         fifo_ready_i;
  logic         fifo_yumi_i;
  logic [1:0]   grant_id_o;
  logic         locked_o;
  logic [2:0]   occupancy_o;
  logic         err_o;

  int n_cmp;
  int n_fail;

  bsg_fifo_rr_enq_arb #(
    .num_req_p(4), .width_p(32), .els_p(4), .lock_packets_p(1)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .v_i          (v_i),
    .data_i       (data_i),
    .last_i       (last_i),
    .ready_o      (ready_o),
    .fifo_v_o     (fifo_v_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_ready_i (fifo_ready_i),
    .fifo_yumi_i  (fifo_yumi_i),
    .grant_id_o   (grant_id_o),
    .locked_o     (locked_o),
    .occupancy_o  (occupancy_o),
    .err_o        (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [3:0] one_hot;
    n_cmp = 0;
    n_fail = 0;
    reset_n_i = 1'b0;
    v_i = '0;
    last_i = '0;
    fifo_ready_i = 1'b1;
    fifo_yumi_i = 1'b0;
    for (int i = 0; i < 4; i++) data_i[i*32 +: 32] = 32'hA0 + 32'(i);

    #12;
    chk("rst_locked", 32'(locked_o), 0);
    chk("rst_occ", 32'(occupancy_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_fifo_v", 32'(fifo_v_o), 0);
    chk("rst_ready", 32'(ready_o), 0);
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;

    // Fairness: everyone valid with single-beat packets
    v_i = 4'hF;
    last_i = 4'hF;
    for (int g = 0; g < 4; g++) begin
      #1;
      one_hot = 4'b0001 << g;
      chk("fair_grant", 32'(grant_id_o), 32'(g));
      chk("fair_ready", 32'(ready_o), 32'(one_hot));
      chk("fair_data", fifo_data_o, 32'hA0 + 32'(g));
      tick();
      chk("fair_occ", 32'(occupancy_o), 32'(g + 1));
    end

    // Backpressure at full
    fifo_ready_i = 1'b0;
    #1;
    chk("bp_ready", 32'(ready_o), 0);
    chk("bp_grant", 32'(grant_id_o), 0);
    tick();
    chk("bp_occ", 32'(occupancy_o), 4);
    chk("bp_err", 32'(err_o), 0);
    fifo_ready_i = 1'b1;
    fifo_yumi_i = 1'b1;
    #1;
    chk("bp_both_ready", 32'(ready_o), 32'h1);
    tick();
    chk("bp_both_occ", 32'(occupancy_o), 4);
    chk("bp_both_err", 32'(err_o), 0);
    v_i = '0;
    repeat (4) tick();
    chk("drain1_occ", 32'(occupancy_o), 0);
    chk("drain1_err", 32'(err_o), 0);
    fifo_yumi_i = 1'b0;

    // Packet lock: requester 2 sends three beats, 0 and 3 waiting
    v_i = 4'b1101;
    last_i = 4'b1001;
    #1;
    chk("lk_b1_grant", 32'(grant_id_o), 2);
    chk("lk_b1_unlocked", 32'(locked_o), 0);
    tick();
    chk("lk_b1_locked", 32'(locked_o), 1);
    chk("lk_b1_occ", 32'(occupancy_o), 1);
    #1;
    chk("lk_b2_grant", 32'(grant_id_o), 2);
    tick();
    chk("lk_b2_locked", 32'(locked_o), 1);
    chk("lk_b2_occ", 32'(occupancy_o), 2);
    last_i = 4'b1101;
    #1;
    chk("lk_b3_grant", 32'(grant_id_o), 2);
    chk("lk_b3_locked", 32'(locked_o), 1);
    tick();
    chk("lk_end_locked", 32'(locked_o), 0);
    chk("lk_end_occ", 32'(occupancy_o), 3);
    v_i = 4'b1001;
    fifo_yumi_i = 1'b1;
    #1;
    chk("lk_next3", 32'(grant_id_o), 3);
    tick();
    chk("lk_next3_occ", 32'(occupancy_o), 3);
    #1;
    chk("lk_next0", 32'(grant_id_o), 0);
    tick();
    v_i = '0;
    repeat (3) tick();
    chk("drain2_occ", 32'(occupancy_o), 0);
    fifo_yumi_i = 1'b0;

    // Owner bubble: requester 1 locks, then drops valid for two cycles
    v_i = 4'b1011;
    last_i = 4'b1001;
    #1;
    chk("bub_grant", 32'(grant_id_o), 1);
    tick();
    chk("bub_locked", 32'(locked_o), 1);
    v_i = 4'b1001;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bub_fifo_v", 32'(fifo_v_o), 0);
      chk("bub_hold_grant", 32'(grant_id_o), 1);
      chk("bub_ready", 32'(ready_o), 32'h2);
      tick();
      chk("bub_still_locked", 32'(locked_o), 1);
      chk("bub_occ", 32'(occupancy_o), 1);
    end
    v_i = 4'b1011;
    last_i = 4'b1011;
    #1;
    chk("bub_resume_v", 32'(fifo_v_o), 1);
    chk("bub_resume_grant", 32'(grant_id_o), 1);
    tick();
    chk("bub_end_locked", 32'(locked_o), 0);
    chk("bub_end_occ", 32'(occupancy_o), 2);

    // Underflow: drain, then one extra yumi
    v_i = '0;
    fifo_yumi_i = 1'b1;
    repeat (2) tick();
    chk("drain3_occ", 32'(occupancy_o), 0);
    chk("drain3_err", 32'(err_o), 0);
    tick();
    chk("uf_err", 32'(err_o), 1);
    chk("uf_occ", 32'(occupancy_o), 0);
    fifo_yumi_i = 1'b0;
    v_i = 4'b0001;
    last_i = 4'b0001;
    #1;
    chk("uf_traffic_grant", 32'(grant_id_o), 0);
    tick();
    chk("uf_sticky", 32'(err_o), 1);
    chk("uf_traffic_occ", 32'(occupancy_o), 1);

    // Reset mid-packet: requester 3 locks, then reset asserted
    v_i = 4'b1001;
    last_i = 4'b0001;
    #1;
    chk("rmp_grant", 32'(grant_id_o), 3);
    tick();
    chk("rmp_locked", 32'(locked_o), 1);
    chk("rmp_occ", 32'(occupancy_o), 2);
    reset_n_i = 1'b0;
    #1;
    chk("rmp_rst_locked", 32'(locked_o), 0);
    chk("rmp_rst_occ", 32'(occupancy_o), 0);
    chk("rmp_rst_err", 32'(err_o), 0);
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    #1;
    chk("rmp_first_grant", 32'(grant_id_o), 0);
    chk("rmp_first_ready", 32'(ready_o), 32'h1);
    chk("rmp_first_data", fifo_data_o, 32'hA0);

    // Overflow: five enqueues into a depth-4 mirror
    v_i = 4'hF;
    last_i = 4'hF;
    repeat (4) tick();
    chk("of_full_occ", 32'(occupancy_o), 4);
    chk("of_full_err", 32'(err_o), 0);
    tick();
    chk("of_err", 32'(err_o), 1);
    chk("of_sat_occ", 32'(occupancy_o), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
